// File: rtl/arcade_cfg_pkg.sv
// Shared types and helpers for the arcade configuration loader:
// FSM state encoding, default ioctl indices and the mod one-hot decoder.
package arcade_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_IDLE,
    ST_LOAD_ROM,
    ST_LOAD_CFG,
    ST_COMMIT
  } cfg_state_e;

  localparam logic [7:0] DEF_ROM_INDEX = 8'd0;
  localparam logic [7:0] DEF_MOD_INDEX = 8'd1;
  localparam logic [7:0] DEF_DIP_INDEX = 8'd254;

  // Full-width decode; callers keep the low NUM_MODS bits, so ids past the
  // vector width naturally decode to all zeros.
  function automatic logic [255:0] onehot_decode(input logic [7:0] id);
    logic [255:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arcade_reset_stretch.sv
// Core reset stretcher: loads RESET_HOLD, counts down to zero, and holds
// core_reset high while the count is non-zero.
module arcade_reset_stretch #(
  parameter int RESET_HOLD = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  output logic busy,
  output logic core_reset
);

  localparam int CW = $clog2(RESET_HOLD + 1);
  localparam logic [CW-1:0] HOLD_VAL = CW'(RESET_HOLD);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= HOLD_VAL;
    end else if (load) begin
      cnt_reg <= HOLD_VAL;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // busy means at least one more reset cycle follows the current one
  assign busy       = (cnt_reg > CW'(1));
  assign core_reset = (cnt_reg != '0);

endmodule

// File: rtl/arcade_cfg_loader.sv
// Captures mod byte and DIP block from the ioctl stream, commits them atomically
// at download end and stretches core reset. Optional readback: CFG_READBACK_EN.
module arcade_cfg_loader
  import arcade_cfg_pkg::*;
#(
  parameter int         NUM_DIP     = 8,
  parameter int         NUM_MODS    = 32,
  parameter logic [7:0] ROM_INDEX   = DEF_ROM_INDEX,
  parameter logic [7:0] MOD_INDEX   = DEF_MOD_INDEX,
  parameter logic [7:0] DIP_INDEX   = DEF_DIP_INDEX,
  parameter logic [7:0] DIP_DEFAULT = 8'hFF,
  parameter int         RESET_HOLD  = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_upload,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
`ifdef CFG_READBACK_EN
  output logic [7:0]             cfg_din,
`endif
  output logic [7:0]             mod_id,
  output logic [NUM_MODS-1:0]    mod_onehot,
  output logic [8*NUM_DIP-1:0]   dip,
  output logic                   cfg_valid,
  output logic                   core_reset
);

  localparam int AW = (NUM_DIP > 1) ? $clog2(NUM_DIP) : 1;
  localparam logic [24:0] DIP_LIMIT = 25'(NUM_DIP);

  cfg_state_e state_reg, state_next;
  logic dl_q_reg;
  logic rise, fall, rise_rom, rise_cfg;
  logic cfg_start, cfg_wr_en, commit_en;
  logic stretch_load, stretch_clear, stretch_busy, stretch_core_reset;
  logic cfg_is_dip_reg, cfg_valid_reg;
  logic [7:0] mod_shadow_reg, mod_id_reg;
  logic [NUM_MODS-1:0] mod_onehot_reg;
  logic [255:0] onehot_full;
  logic onehot_unused;

  assign rise     = ioctl_download & ~dl_q_reg;
  assign fall     = ~ioctl_download & dl_q_reg;
  assign rise_rom = rise && (ioctl_index == ROM_INDEX);
  assign rise_cfg = rise && ((ioctl_index == MOD_INDEX) || (ioctl_index == DIP_INDEX));

  // dl_q resets high so a download already in flight at reset is not seen as a new one
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_HOLD;
      dl_q_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      dl_q_reg  <= ioctl_download;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (rise_rom)                              state_next = ST_LOAD_ROM;
        else if (rise_cfg)                         state_next = ST_LOAD_CFG;
        else if (state_reg == ST_HOLD && !stretch_busy) state_next = ST_IDLE;
      end
      ST_LOAD_ROM: if (fall) state_next = ST_HOLD;
      ST_LOAD_CFG: if (fall) state_next = ST_COMMIT;
      ST_COMMIT:   state_next = cfg_is_dip_reg ? ST_IDLE : ST_HOLD;
      default:     state_next = ST_HOLD;
    endcase
  end

  always_comb begin
    stretch_load  = (state_next == ST_HOLD) && (state_reg != ST_HOLD);
    stretch_clear = (state_reg == ST_HOLD) && (state_next != ST_HOLD);
    cfg_start     = (state_next == ST_LOAD_CFG) && (state_reg != ST_LOAD_CFG);
    cfg_wr_en     = (state_reg == ST_LOAD_CFG) && ioctl_download && ioctl_wr;
    commit_en     = (state_reg == ST_COMMIT);
    core_reset    = stretch_core_reset || (state_reg == ST_LOAD_ROM);
  end

  arcade_reset_stretch #(
    .RESET_HOLD (RESET_HOLD)
  ) u_reset_stretch (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load       (stretch_load),
    .clear      (stretch_clear),
    .busy       (stretch_busy),
    .core_reset (stretch_core_reset)
  );

  assign onehot_full   = onehot_decode(mod_shadow_reg);
  assign onehot_unused = &{1'b0, onehot_full};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod_shadow_reg <= 8'd0;
      mod_id_reg     <= 8'd0;
      mod_onehot_reg <= NUM_MODS'(1);
      cfg_is_dip_reg <= 1'b0;
      cfg_valid_reg  <= 1'b0;
    end else begin
      if (cfg_start) begin
        mod_shadow_reg <= mod_id_reg;
        cfg_is_dip_reg <= (ioctl_index == DIP_INDEX);
      end else if (cfg_wr_en && !cfg_is_dip_reg && ioctl_addr == 25'd0) begin
        mod_shadow_reg <= ioctl_dout;
      end
      if (commit_en) begin
        mod_id_reg     <= mod_shadow_reg;
        mod_onehot_reg <= onehot_full[NUM_MODS-1:0];
        if (cfg_is_dip_reg) cfg_valid_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIP; gi++) begin : g_dip
      logic [7:0] byte_reg, shadow_reg;
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          byte_reg   <= DIP_DEFAULT;
          shadow_reg <= DIP_DEFAULT;
        end else begin
          if (cfg_start)
            shadow_reg <= byte_reg;
          else if (cfg_wr_en && cfg_is_dip_reg && ioctl_addr == 25'(gi))
            shadow_reg <= ioctl_dout;
          if (commit_en) byte_reg <= shadow_reg;
        end
      end
      assign dip[8*gi +: 8] = byte_reg;
    end
  endgenerate

`ifdef CFG_READBACK_EN
  logic [7:0] cfg_din_reg;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      cfg_din_reg <= 8'd0;
    else if (ioctl_upload && ioctl_index == DIP_INDEX && ioctl_addr < DIP_LIMIT)
      cfg_din_reg <= dip[{ioctl_addr[AW-1:0], 3'b000} +: 8];
    else
      cfg_din_reg <= 8'd0;
  end
  assign cfg_din = cfg_din_reg;
`else
  logic upload_unused;
  assign upload_unused = ioctl_upload;
`endif

  assign mod_id     = mod_id_reg;
  assign mod_onehot = mod_onehot_reg;
  assign cfg_valid  = cfg_valid_reg;

endmodule
